sn76489_control: RTL and testbench
==================================

Name: sn76489_control

Overview:
Register front end and sequencer for the PSG inside the 315-5124: decodes CPU bytes written to the PSG port (latch/data protocol) into per-channel tone periods, attenuations and noise control. Generates the shared divide-by-16 clock enable for the tone and noise generators, and the noise-LFSR reset pulse. Outputs connect directly to three sn76489 tone generators and to sn76489_noise_generator (n, noiseFeedbackType, att, enable).

Parameters:
CLK_DIV, 16, clocks per enable pulse (power of two, 2..256).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
wr  in  1  write strobe, one byte accepted per cycle while high
data  in  8  byte from CPU PSG port
enable  out  1  one-cycle clock enable, every CLK_DIV cycles
tone0_n, tone1_n, tone2_n  out  10 each  tone half-period registers
noise_n  out  10  effective noise shift period
noiseFeedbackType  out  1  0 periodic, 1 white
noise_reset  out  1  one-cycle pulse: reload noise LFSR
att0, att1, att2, att3  out  4 each  attenuation, 4'hF = off; att3 = noise

Behaviour:
- Reset: applies when reset is low at a clk edge; dominates wr. All tone n = 0, all att = 4'hF, noise ctrl (FB, NF) = 0, latch = {ch0, tone}, divider = 0, enable = 0, noise_reset = 0.
- Byte decode when wr is high at a clk edge; new register values are visible the next cycle (1-cycle latency). No backpressure.
- Latch byte (data[7]=1): latch.ch = data[6:5], latch.type = data[4] (1 = att, 0 = tone/noise). Then:
  - type 1: att<ch> = data[3:0].
  - type 0, ch 0..2: tone<ch>_n[3:0] = data[3:0]; [9:4] unchanged.
  - type 0, ch 3: FB = data[2], NF = data[1:0]; noise_reset pulses.
- Data byte (data[7]=0): uses the held latch.
  - att: att<ch> = data[3:0].
  - tone: tone<ch>_n[9:4] = data[5:0]; data[6] ignored.
  - noise: FB/NF = data[2:0]; noise_reset pulses.
- noise_reset is high for exactly one cycle, the cycle in which the new FB/NF is visible. Back-to-back noise writes give consecutive pulses.
- noiseFeedbackType = FB.
- noise_n is combinational from NF:
  - 0 gives 16, 1 gives 32, 2 gives 64.
  - 3 gives the current tone2_n. It tracks later tone2 writes with no further noise_reset.
- Divider:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - enable is registered high in the cycle after the counter reaches CLK_DIV-1.
  - First enable appears 16 cycles after reset is released (15 low, 1 high), then period 16. Not affected by wr.
- Simultaneous wr and enable: both take effect. Generators see the old values on that enable and the new values from the next cycle.
- Reset mid-sequence, e.g. between a latch and a data byte: the latch returns to {ch0, tone}, so a following data byte writes tone0_n[9:4].

Decomposition:
- Shared include sn76489_defs.vh:
  - ATT_OFF = 4'hF.
  - Latch type codes.
  - Channel indices 0..3.
  - NF codes and the fixed periods 16/32/64.
  - Feedback codes NOISE_FEEDBACK_TYPE_PERIODIC = 0, NOISE_FEEDBACK_TYPE_WHITE_NOISE = 1.
- One sub-module: sn76489_clock_divider (clk, reset, enable; parameter CLK_DIV), also reusable by the tone generators' bench.
- The register file and decode stay in sn76489_control.

Test Plan:
1. Reset, then idle 48 cycles → enable high only on cycles 16, 32, 48; all att = F, all tone_n = 0, noise_n = 16, noise_reset never high.
2. Write 0x8E then 0x0F → tone0_n = 0x0FE one cycle after the second byte; tone1_n and tone2_n still 0.
3. Write 0x9A, then 0xF3, then 0x05 → att0 = A; att3 = 3; the data byte 0x05 (latch = ch3 att) sets att3 = 5.
4. Write 0xE5 → FB = 1, noise_n = 32, one noise_reset pulse. Then 0xE6 → noise_n = 64 and a second pulse. Then 0xC4, 0x02 → tone2_n = 0x024. Then 0xE3 → noise_n = 0x024, FB = 0; a later 0xC1 gives noise_n = 0x021 with no pulse.
5. Issue wr = 1 with data 0x9F in the same cycle reset is low → att0 stays F and the latch stays ch0 tone. Then 0x3F → tone0_n = 0x3F0.
6. Issue wr with 0xE4 on the cycle enable is asserted → enable timing unchanged; noise_reset and the new values appear the next cycle.

Source files
------------

// File: rtl/sn76489_control_pkg.sv
// Shared constants for the SN76489 PSG register front end: latch codes,
// channel indices, noise frequency codes/periods and feedback codes.
package sn76489_control_pkg;

  localparam logic [3:0] ATT_OFF = 4'hF;

  localparam logic LATCH_TYPE_TONE = 1'b0;
  localparam logic LATCH_TYPE_ATT  = 1'b1;

  localparam logic [1:0] CH_TONE0 = 2'd0;
  localparam logic [1:0] CH_TONE1 = 2'd1;
  localparam logic [1:0] CH_TONE2 = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

  localparam logic [1:0] NF_DIV16 = 2'd0;
  localparam logic [1:0] NF_DIV32 = 2'd1;
  localparam logic [1:0] NF_DIV64 = 2'd2;
  localparam logic [1:0] NF_TONE2 = 2'd3;

  localparam logic [9:0] NOISE_PERIOD_16 = 10'd16;
  localparam logic [9:0] NOISE_PERIOD_32 = 10'd32;
  localparam logic [9:0] NOISE_PERIOD_64 = 10'd64;

  localparam logic NOISE_FEEDBACK_TYPE_PERIODIC    = 1'b0;
  localparam logic NOISE_FEEDBACK_TYPE_WHITE_NOISE = 1'b1;

  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } latch_t;

  localparam latch_t LATCH_RESET = '{ch: CH_TONE0, typ: LATCH_TYPE_TONE};

endpackage

// File: rtl/sn76489_clock_divider.sv
// Free-running 0..CLK_DIV-1 counter producing a registered one-cycle enable
// in the cycle after the counter reaches its terminal value.
module sn76489_clock_divider #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic enable
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enable_q, enable_d;

  always_comb begin
    enable_d = (cnt_q == CNT_LAST);
    cnt_d    = enable_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
    end
  end

  assign enable = enable_q;

endmodule

// File: rtl/sn76489_control.sv
// PSG register front end: decodes latch/data bytes into tone periods,
// attenuations and noise control, and hosts the shared clock divider.
module sn76489_control
  import sn76489_control_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       enable,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [9:0] noise_n,
  output logic       noiseFeedbackType,
  output logic       noise_reset,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3
);

  logic [2:0][9:0] tone_q, tone_d;
  logic [3:0][3:0] att_q, att_d;
  logic            fb_q, fb_d;
  logic [1:0]      nf_q, nf_d;
  latch_t          latch_q, latch_d;
  logic            noise_reset_q, noise_reset_d;

  sn76489_clock_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable)
  );

  // A latch byte updates the latch and then writes through it, so both byte
  // kinds share one target-selection path keyed on the new latch value.
  always_comb begin
    tone_d        = tone_q;
    att_d         = att_q;
    fb_d          = fb_q;
    nf_d          = nf_q;
    latch_d       = latch_q;
    noise_reset_d = 1'b0;
    if (wr) begin
      if (data[7]) begin
        latch_d.ch  = data[6:5];
        latch_d.typ = data[4];
      end
      if (latch_d.typ == LATCH_TYPE_ATT) begin
        att_d[latch_d.ch] = data[3:0];
      end else if (latch_d.ch == CH_NOISE) begin
        fb_d          = data[2];
        nf_d          = data[1:0];
        noise_reset_d = 1'b1;
      end else if (data[7]) begin
        tone_d[latch_d.ch][3:0] = data[3:0];
      end else begin
        tone_d[latch_d.ch][9:4] = data[5:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tone_q        <= '0;
      att_q         <= {4{ATT_OFF}};
      fb_q          <= NOISE_FEEDBACK_TYPE_PERIODIC;
      nf_q          <= NF_DIV16;
      latch_q       <= LATCH_RESET;
      noise_reset_q <= 1'b0;
    end else begin
      tone_q        <= tone_d;
      att_q         <= att_d;
      fb_q          <= fb_d;
      nf_q          <= nf_d;
      latch_q       <= latch_d;
      noise_reset_q <= noise_reset_d;
    end
  end

  // Rate 3 borrows tone2's period live, so later tone2 writes retune noise.
  always_comb begin
    unique case (nf_q)
      NF_DIV16: noise_n = NOISE_PERIOD_16;
      NF_DIV32: noise_n = NOISE_PERIOD_32;
      NF_DIV64: noise_n = NOISE_PERIOD_64;
      default:  noise_n = tone_q[CH_TONE2];
    endcase
  end

  assign tone0_n           = tone_q[0];
  assign tone1_n           = tone_q[1];
  assign tone2_n           = tone_q[2];
  assign att0              = att_q[0];
  assign att1              = att_q[1];
  assign att2              = att_q[2];
  assign att3              = att_q[3];
  assign noiseFeedbackType = fb_q;
  assign noise_reset       = noise_reset_q;

endmodule

// File: tb/tb_sn76489_control.sv
// Bench for sn76489_control: directed plan items plus random byte streams
// checked every cycle against a behavioural register-map model.
module tb_sn76489_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] data;
  logic       enable;
  logic [9:0] tone0_n, tone1_n, tone2_n, noise_n;
  logic       noiseFeedbackType, noise_reset;
  logic [3:0] att0, att1, att2, att3;

  sn76489_control #(.CLK_DIV(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr                (wr),
    .data              (data),
    .enable            (enable),
    .tone0_n           (tone0_n),
    .tone1_n           (tone1_n),
    .tone2_n           (tone2_n),
    .noise_n           (noise_n),
    .noiseFeedbackType (noiseFeedbackType),
    .noise_reset       (noise_reset),
    .att0              (att0),
    .att1              (att1),
    .att2              (att2),
    .att3              (att3)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the PSG register map as plain integers.
  int m_tone[3];
  int m_att[4];
  int m_fb, m_nf, m_lch, m_ltyp;
  int m_since_rst;
  int m_en, m_nr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int m_noise_n();
    return (m_nf == 3) ? m_tone[2] : (16 << m_nf);
  endfunction

  function automatic void m_apply(input bit w, input int d, input bit rst_n);
    m_nr = 0;
    if (!rst_n) begin
      foreach (m_tone[i]) m_tone[i] = 0;
      foreach (m_att[i])  m_att[i]  = 15;
      m_fb = 0; m_nf = 0; m_lch = 0; m_ltyp = 0;
      m_since_rst = 0;
      m_en = 0;
      return;
    end
    m_since_rst++;
    m_en = (m_since_rst % 16 == 0) ? 1 : 0;
    if (!w) return;
    if (d >= 128) begin
      m_lch  = (d / 32) % 4;
      m_ltyp = (d / 16) % 2;
    end
    if (m_ltyp == 1)
      m_att[m_lch] = d % 16;
    else if (m_lch == 3) begin
      m_fb = (d / 4) % 2;
      m_nf = d % 4;
      m_nr = 1;
    end else if (d >= 128)
      m_tone[m_lch] = (m_tone[m_lch] / 16) * 16 + d % 16;
    else
      m_tone[m_lch] = (d % 64) * 16 + m_tone[m_lch] % 16;
  endfunction

  task automatic check_all();
    chk("enable", enable, m_en);
    chk("noise_reset", noise_reset, m_nr);
    chk("fb", noiseFeedbackType, m_fb);
    chk("noise_n", noise_n, m_noise_n());
    chk("tone0", tone0_n, m_tone[0]);
    chk("tone1", tone1_n, m_tone[1]);
    chk("tone2", tone2_n, m_tone[2]);
    chk("att0", att0, m_att[0]);
    chk("att1", att1, m_att[1]);
    chk("att2", att2, m_att[2]);
    chk("att3", att3, m_att[3]);
  endtask

  // Drive one cycle: inputs settle between edges, outputs sampled 1 after.
  task automatic step(input bit w, input logic [7:0] d, input bit rst_n);
    wr = w; data = d; reset = rst_n;
    @(posedge clk);
    m_apply(w, int'(d), rst_n);
    #1;
    check_all();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    step(1'b1, d, 1'b1);
  endtask

  int en_seen;
  bit nr_seen;

  initial begin
    wr = 1'b0; data = 8'h00; reset = 1'b0;
    m_apply(1'b0, 0, 1'b0);

    // 1: reset, then 48 idle cycles
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    en_seen = 0; nr_seen = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (enable) en_seen += i;
      if (noise_reset) nr_seen = 1'b1;
    end
    chk("idle_en_cycles", en_seen, 16 + 32 + 48);
    chk("idle_nr_never", nr_seen, 0);
    chk("idle_noise_n", noise_n, 16);
    chk("idle_att3", att3, 4'hF);

    // 2: tone0 two-byte write
    wr_byte(8'h8E);
    wr_byte(8'h0F);
    chk("t2_tone0", tone0_n, 10'h0FE);
    chk("t2_tone1", tone1_n, 10'h000);

    // 3: attenuation latch and data bytes
    wr_byte(8'h9A);
    chk("t3_att0", att0, 4'hA);
    wr_byte(8'hF3);
    chk("t3_att3_latch", att3, 4'h3);
    wr_byte(8'h05);
    chk("t3_att3_data", att3, 4'h5);

    // 4: noise control and tone2-tracking rate
    wr_byte(8'hE5);
    chk("t4_fb", noiseFeedbackType, 1);
    chk("t4_n32", noise_n, 32);
    chk("t4_pulse1", noise_reset, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_pulse_end", noise_reset, 0);
    wr_byte(8'hE6);
    chk("t4_n64", noise_n, 64);
    chk("t4_pulse2", noise_reset, 1);
    wr_byte(8'hC4);
    wr_byte(8'h02);
    chk("t4_tone2", tone2_n, 10'h024);
    wr_byte(8'hE3);
    chk("t4_n_tone2", noise_n, 10'h024);
    chk("t4_fb0", noiseFeedbackType, 0);
    wr_byte(8'hC1);
    chk("t4_n_track", noise_n, 10'h021);
    chk("t4_no_pulse", noise_reset, 0);

    // back-to-back noise writes
    wr_byte(8'hE0);
    wr_byte(8'h01);
    chk("b2b_pulse", noise_reset, 1);
    chk("b2b_n32", noise_n, 32);

    // 5: write during reset is discarded
    wr_byte(8'h9F);
    wr_byte(8'h00);
    step(1'b1, 8'h9F, 1'b0);
    chk("t5_att0", att0, 4'hF);
    wr_byte(8'h3F);
    chk("t5_tone0", tone0_n, 10'h3F0);

    // 6: write coincident with enable
    for (int i = 0; i < 40 && !enable; i++) step(1'b0, 8'h00, 1'b1);
    chk("t6_en_before", enable, 1);
    wr_byte(8'hE4);
    chk("t6_en_after", enable, 0);
    chk("t6_pulse", noise_reset, 1);
    chk("t6_fb", noiseFeedbackType, 1);

    // reset between latch and data byte
    wr_byte(8'hD0);
    step(1'b0, 8'h00, 1'b0);
    wr_byte(8'h2A);
    chk("mid_rst_tone0", tone0_n, 10'h2A0);
    chk("mid_rst_att2", att2, 4'hF);

    // random byte streams with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 127) == 0) ? 1'b0 : 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
